// File: rtl/bp_nonsynth_commit_joiner.sv
// Pairs in-order commit records with per-register writeback data and presents
// one complete retire record per cycle over a valid/yumi handshake.
module bp_nonsynth_commit_joiner #(
    parameter int vaddr_width_p     = 39,
    parameter int data_width_p      = 64,
    parameter int lg_commit_els_p   = 4,
    parameter int wb_els_p          = 2,
    parameter int fp_en_p           = 1,
    parameter int watchdog_cycles_p = 4096,
    parameter int cnt_width_p       = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     en_i,
    input  logic                     commit_v_i,
    input  logic [vaddr_width_p-1:0] commit_pc_i,
    input  logic [31:0]              commit_instr_i,
    input  logic                     commit_ird_w_v_i,
    input  logic                     commit_frd_w_v_i,
    input  logic                     commit_trap_i,
    input  logic [63:0]              commit_cause_i,
    input  logic                     commit_debug_i,
    input  logic                     ird_w_v_i,
    input  logic [4:0]               ird_addr_i,
    input  logic [data_width_p-1:0]  ird_data_i,
    input  logic                     frd_w_v_i,
    input  logic [4:0]               frd_addr_i,
    input  logic [data_width_p-1:0]  frd_data_i,
    input  logic [cnt_width_p-1:0]   instr_cap_i,
    output logic                     retire_v_o,
    input  logic                     retire_yumi_i,
    output logic [vaddr_width_p-1:0] retire_pc_o,
    output logic [31:0]              retire_instr_o,
    output logic                     retire_trap_o,
    output logic [63:0]              retire_cause_o,
    output logic                     retire_rd_w_v_o,
    output logic                     retire_rd_fp_o,
    output logic [4:0]               retire_rd_addr_o,
    output logic [data_width_p-1:0]  retire_rd_data_o,
    output logic [cnt_width_p-1:0]   instr_cnt_o,
    output logic                     cap_reached_o,
    output logic                     watchdog_o,
    output logic [2:0]               overrun_o
);
    localparam int CE  = 1 << lg_commit_els_p;
    localparam int CW  = lg_commit_els_p;
    localparam int PW  = (wb_els_p > 1) ? $clog2(wb_els_p) : 1;
    localparam int WDW = (watchdog_cycles_p > 1) ? $clog2(watchdog_cycles_p + 1) : 1;
    localparam logic [WDW-1:0] WD_LIM = WDW'(watchdog_cycles_p);
    localparam logic WD_ON = (watchdog_cycles_p != 0);
    localparam logic FP_EN = (fp_en_p != 0);

    logic [vaddr_width_p-1:0] c_pc_q    [CE];
    logic [31:0]              c_instr_q [CE];
    logic [63:0]              c_cause_q [CE];
    logic                     c_ird_q   [CE];
    logic                     c_frd_q   [CE];
    logic                     c_trap_q  [CE];
    logic                     c_dbg_q   [CE];
    logic [data_width_p-1:0]  imem_q [32][wb_els_p];
    logic [data_width_p-1:0]  fmem_q [32][wb_els_p];

    logic [CW:0] cw_q, cw_d, cr_q, cr_d;
    logic [PW:0] iw_q [32], iw_d [32], ir_q [32], ir_d [32];
    logic [PW:0] fw_q [32], fw_d [32], fr_q [32], fr_d [32];
    logic [cnt_width_p-1:0] cnt_q, cnt_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic cap_q, cap_d, wdf_q, wdf_d;
    logic [2:0] ovf_q, ovf_d;

    // Per-register pointers wrap at wb_els_p, which need not be a power of two.
    function automatic logic [PW:0] ptr_inc(input logic [PW:0] p);
        logic [PW:0] r;
        r = p;
        if (p[PW-1:0] == PW'(wb_els_p - 1)) begin
            r[PW-1:0] = '0;
            r[PW]     = ~p[PW];
        end else begin
            r[PW-1:0] = p[PW-1:0] + PW'(1);
        end
        return r;
    endfunction

    function automatic logic pfull(input logic [PW:0] w, input logic [PW:0] r);
        return (w[PW] != r[PW]) && (w[PW-1:0] == r[PW-1:0]);
    endfunction

    logic [CW-1:0] hidx;
    logic [4:0] rd;
    logic c_empty, c_full, need_i, need_f, ready, rv, deq, stall;
    logic c_try, c_enq, i_try, i_enq, f_try, f_enq, cnt_inc;

    always_comb begin
        hidx    = cr_q[CW-1:0];
        rd      = c_instr_q[hidx][11:7];
        c_empty = (cw_q == cr_q);
        c_full  = (cw_q[CW] != cr_q[CW]) && (cw_q[CW-1:0] == cr_q[CW-1:0]);
        need_i  = c_ird_q[hidx] & ~c_trap_q[hidx] & (rd != 5'd0);
        need_f  = c_frd_q[hidx] & ~c_trap_q[hidx] & FP_EN;
        ready   = ~c_empty & (~need_i | (iw_q[rd] != ir_q[rd]))
                           & (~need_f | (fw_q[rd] != fr_q[rd]));
        rv      = ready & ~c_dbg_q[hidx] & ~cap_q;
        deq     = (ready & c_dbg_q[hidx]) | (rv & retire_yumi_i);
        stall   = ~ready | (rv & ~retire_yumi_i);
        c_try   = commit_v_i & en_i & ~cap_q;
        c_enq   = c_try & ~c_full;
        i_try   = ird_w_v_i & (ird_addr_i != 5'd0);
        i_enq   = i_try & ~pfull(iw_q[ird_addr_i], ir_q[ird_addr_i]);
        f_try   = frd_w_v_i & FP_EN;
        f_enq   = f_try & ~pfull(fw_q[frd_addr_i], fr_q[frd_addr_i]);
        cnt_inc = rv & retire_yumi_i & ~c_trap_q[hidx];
    end

    always_comb begin
        cw_d  = c_enq ? cw_q + (CW+1)'(1) : cw_q;
        cr_d  = deq ? cr_q + (CW+1)'(1) : cr_q;
        iw_d  = iw_q;
        ir_d  = ir_q;
        fw_d  = fw_q;
        fr_d  = fr_q;
        cnt_d = cnt_q;
        cap_d = cap_q;
        wd_d  = wd_q;
        wdf_d = wdf_q;
        ovf_d = ovf_q | {f_try & ~f_enq, i_try & ~i_enq, c_try & ~c_enq};
        if (i_enq) iw_d[ird_addr_i] = ptr_inc(iw_q[ird_addr_i]);
        if (f_enq) fw_d[frd_addr_i] = ptr_inc(fw_q[frd_addr_i]);
        if (deq & need_i) ir_d[rd] = ptr_inc(ir_q[rd]);
        if (deq & need_f) fr_d[rd] = ptr_inc(fr_q[rd]);
        if (cnt_inc && (cnt_q != '1)) cnt_d = cnt_q + cnt_width_p'(1);
        if (cnt_inc && (instr_cap_i != '0) && (cnt_d == instr_cap_i)) cap_d = 1'b1;
        if (c_empty | deq) begin
            wd_d = '0;
        end else if (stall && (wd_q != WD_LIM)) begin
            wd_d = wd_q + WDW'(1);
            if (WD_ON && (wd_d == WD_LIM)) wdf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cw_q  <= '0;
            cr_q  <= '0;
            cnt_q <= '0;
            cap_q <= 1'b0;
            wd_q  <= '0;
            wdf_q <= 1'b0;
            ovf_q <= '0;
            for (int i = 0; i < 32; i++) begin
                iw_q[i] <= '0;
                ir_q[i] <= '0;
                fw_q[i] <= '0;
                fr_q[i] <= '0;
            end
        end else begin
            cw_q  <= cw_d;
            cr_q  <= cr_d;
            cnt_q <= cnt_d;
            cap_q <= cap_d;
            wd_q  <= wd_d;
            wdf_q <= wdf_d;
            ovf_q <= ovf_d;
            iw_q  <= iw_d;
            ir_q  <= ir_d;
            fw_q  <= fw_d;
            fr_q  <= fr_d;
        end
    end

    // Storage carries no reset; validity is defined by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (c_enq) begin
            c_pc_q[cw_q[CW-1:0]]    <= commit_pc_i;
            c_instr_q[cw_q[CW-1:0]] <= commit_instr_i;
            c_cause_q[cw_q[CW-1:0]] <= commit_cause_i;
            c_ird_q[cw_q[CW-1:0]]   <= commit_ird_w_v_i;
            c_frd_q[cw_q[CW-1:0]]   <= commit_frd_w_v_i;
            c_trap_q[cw_q[CW-1:0]]  <= commit_trap_i;
            c_dbg_q[cw_q[CW-1:0]]   <= commit_debug_i;
        end
        if (i_enq) imem_q[ird_addr_i][iw_q[ird_addr_i][PW-1:0]] <= ird_data_i;
        if (f_enq) fmem_q[frd_addr_i][fw_q[frd_addr_i][PW-1:0]] <= frd_data_i;
    end

    always_comb begin
        retire_v_o       = rv;
        retire_pc_o      = rv ? c_pc_q[hidx] : '0;
        retire_instr_o   = rv ? c_instr_q[hidx] : '0;
        retire_trap_o    = rv & c_trap_q[hidx];
        retire_cause_o   = rv ? c_cause_q[hidx] : '0;
        retire_rd_w_v_o  = rv & (need_i | need_f);
        retire_rd_fp_o   = rv & need_f;
        retire_rd_addr_o = rv ? rd : '0;
        retire_rd_data_o = '0;
        if (rv & need_f)      retire_rd_data_o = fmem_q[rd][fr_q[rd][PW-1:0]];
        else if (rv & need_i) retire_rd_data_o = imem_q[rd][ir_q[rd][PW-1:0]];
        instr_cnt_o   = cnt_q;
        cap_reached_o = cap_q;
        watchdog_o    = wdf_q;
        overrun_o     = ovf_q;
    end
endmodule

// File: tb/tb_bp_nonsynth_commit_joiner.sv
// Bench for bp_nonsynth_commit_joiner: directed table, hand sequences and
// random traffic, all compared each cycle against a queue-based model.
module tb_bp_nonsynth_commit_joiner;
    localparam int WD = 8;
    localparam int WB = 2;
    localparam int CD = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_i, en_i, commit_v_i, commit_ird_w_v_i, commit_frd_w_v_i;
    logic commit_trap_i, commit_debug_i, ird_w_v_i, frd_w_v_i, retire_yumi_i;
    logic [38:0] commit_pc_i;
    logic [31:0] commit_instr_i, instr_cap_i;
    logic [63:0] commit_cause_i, ird_data_i, frd_data_i;
    logic [4:0]  ird_addr_i, frd_addr_i;
    logic retire_v_o, retire_trap_o, retire_rd_w_v_o, retire_rd_fp_o;
    logic cap_reached_o, watchdog_o;
    logic [38:0] retire_pc_o;
    logic [31:0] retire_instr_o, instr_cnt_o;
    logic [63:0] retire_cause_o, retire_rd_data_o;
    logic [4:0]  retire_rd_addr_o;
    logic [2:0]  overrun_o;

    bp_nonsynth_commit_joiner #(.watchdog_cycles_p(WD)) dut (
        .clk_i(clk), .reset_i(reset_i), .en_i(en_i),
        .commit_v_i(commit_v_i), .commit_pc_i(commit_pc_i),
        .commit_instr_i(commit_instr_i), .commit_ird_w_v_i(commit_ird_w_v_i),
        .commit_frd_w_v_i(commit_frd_w_v_i), .commit_trap_i(commit_trap_i),
        .commit_cause_i(commit_cause_i), .commit_debug_i(commit_debug_i),
        .ird_w_v_i(ird_w_v_i), .ird_addr_i(ird_addr_i), .ird_data_i(ird_data_i),
        .frd_w_v_i(frd_w_v_i), .frd_addr_i(frd_addr_i), .frd_data_i(frd_data_i),
        .instr_cap_i(instr_cap_i), .retire_v_o(retire_v_o),
        .retire_yumi_i(retire_yumi_i), .retire_pc_o(retire_pc_o),
        .retire_instr_o(retire_instr_o), .retire_trap_o(retire_trap_o),
        .retire_cause_o(retire_cause_o), .retire_rd_w_v_o(retire_rd_w_v_o),
        .retire_rd_fp_o(retire_rd_fp_o), .retire_rd_addr_o(retire_rd_addr_o),
        .retire_rd_data_o(retire_rd_data_o), .instr_cnt_o(instr_cnt_o),
        .cap_reached_o(cap_reached_o), .watchdog_o(watchdog_o),
        .overrun_o(overrun_o)
    );

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain queues of records and per-register data lists.
    typedef struct {
        logic [38:0] pc;
        logic [31:0] instr;
        logic ird, frd, trap, dbg;
        logic [63:0] cause;
    } crec_t;

    crec_t       mq[$];
    logic [63:0] mi [32][WB];
    logic [63:0] mf [32][WB];
    int          mic [32];
    int          mfc [32];
    logic [31:0] m_cnt;
    logic        m_cap, m_wdf;
    logic [2:0]  m_ovf;
    int          m_wd;

    function automatic logic [4:0] m_rd();
        return (mq.size() > 0) ? mq[0].instr[11:7] : 5'd0;
    endfunction
    function automatic logic m_ni();
        return (mq.size() > 0) && mq[0].ird && !mq[0].trap && (m_rd() != 5'd0);
    endfunction
    function automatic logic m_nf();
        return (mq.size() > 0) && mq[0].frd && !mq[0].trap;
    endfunction
    function automatic logic m_ready();
        return (mq.size() > 0) && (!m_ni() || mic[m_rd()] > 0) && (!m_nf() || mfc[m_rd()] > 0);
    endfunction
    function automatic logic m_ev();
        return m_ready() && !mq[0].dbg && !m_cap;
    endfunction

    task automatic model_step();
        logic rdy, ev, ni, nf, deq, cap0, ifull, ffull;
        logic [4:0] rd;
        int csz;
        if (reset_i) begin
            mq.delete();
            for (int r = 0; r < 32; r++) begin mic[r] = 0; mfc[r] = 0; end
            m_cnt = '0; m_cap = 0; m_wdf = 0; m_ovf = '0; m_wd = 0;
            return;
        end
        rdy = m_ready(); ev = m_ev(); ni = m_ni(); nf = m_nf(); rd = m_rd();
        cap0 = m_cap;
        csz = mq.size();
        deq = rdy && (mq[0].dbg || (ev && retire_yumi_i));
        ifull = mic[ird_addr_i] == WB;
        ffull = mfc[frd_addr_i] == WB;
        if (ev && retire_yumi_i && !mq[0].trap) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
            if (instr_cap_i != 0 && m_cnt == instr_cap_i) m_cap = 1;
        end
        if (csz == 0 || deq) m_wd = 0;
        else if (!rdy || (ev && !retire_yumi_i)) begin
            m_wd++;
            if (m_wd >= WD) m_wdf = 1;
        end
        if (deq) begin
            if (ni) begin mi[rd][0] = mi[rd][1]; mic[rd]--; end
            if (nf) begin mf[rd][0] = mf[rd][1]; mfc[rd]--; end
            void'(mq.pop_front());
        end
        if (commit_v_i && en_i && !cap0) begin
            if (csz == CD) m_ovf[0] = 1;
            else mq.push_back('{commit_pc_i, commit_instr_i, commit_ird_w_v_i,
                                commit_frd_w_v_i, commit_trap_i, commit_debug_i, commit_cause_i});
        end
        if (ird_w_v_i && ird_addr_i != 0) begin
            if (ifull) m_ovf[1] = 1;
            else begin mi[ird_addr_i][mic[ird_addr_i]] = ird_data_i; mic[ird_addr_i]++; end
        end
        if (frd_w_v_i) begin
            if (ffull) m_ovf[2] = 1;
            else begin mf[frd_addr_i][mfc[frd_addr_i]] = frd_data_i; mfc[frd_addr_i]++; end
        end
    endtask

    task automatic check_all();
        logic ev;
        logic [4:0] rd;
        logic [63:0] d;
        ev = m_ev(); rd = m_rd();
        chk("retire_v", 64'(retire_v_o), 64'(ev));
        if (ev) begin
            d = m_nf() ? mf[rd][0] : (m_ni() ? mi[rd][0] : 64'd0);
            chk("retire_pc", 64'(retire_pc_o), 64'(mq[0].pc));
            chk("retire_instr", 64'(retire_instr_o), 64'(mq[0].instr));
            chk("retire_trap", 64'(retire_trap_o), 64'(mq[0].trap));
            chk("retire_cause", retire_cause_o, mq[0].cause);
            chk("retire_rd_w_v", 64'(retire_rd_w_v_o), 64'(m_ni() | m_nf()));
            chk("retire_rd_fp", 64'(retire_rd_fp_o), 64'(m_nf()));
            chk("retire_rd_addr", 64'(retire_rd_addr_o), 64'(rd));
            chk("retire_rd_data", retire_rd_data_o, d);
        end
        chk("instr_cnt", 64'(instr_cnt_o), 64'(m_cnt));
        chk("cap_reached", 64'(cap_reached_o), 64'(m_cap));
        chk("watchdog", 64'(watchdog_o), 64'(m_wdf));
        chk("overrun", 64'(overrun_o), 64'(m_ovf));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic clr();
        commit_v_i = 0; commit_pc_i = '0; commit_instr_i = '0; commit_ird_w_v_i = 0;
        commit_frd_w_v_i = 0; commit_trap_i = 0; commit_cause_i = '0; commit_debug_i = 0;
        ird_w_v_i = 0; ird_addr_i = '0; ird_data_i = '0;
        frd_w_v_i = 0; frd_addr_i = '0; frd_data_i = '0;
        retire_yumi_i = 0;
    endtask

    task automatic do_reset();
        clr();
        reset_i = 1; cyc(); cyc(); reset_i = 0;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rd);
        return {12'h001, 5'd0, 3'b000, rd, 7'h13};
    endfunction

    task automatic do_commit(input logic [38:0] pc, input logic [31:0] instr, input logic ird,
                             input logic frd, input logic trap, input logic [63:0] cause);
        commit_v_i = 1; commit_pc_i = pc; commit_instr_i = instr; commit_ird_w_v_i = ird;
        commit_frd_w_v_i = frd; commit_trap_i = trap; commit_cause_i = cause; commit_debug_i = 0;
        cyc();
        commit_v_i = 0;
    endtask

    task automatic iwb(input logic [4:0] a, input logic [63:0] d);
        ird_w_v_i = 1; ird_addr_i = a; ird_data_i = d; cyc(); ird_w_v_i = 0;
    endtask

    task automatic fwb(input logic [4:0] a, input logic [63:0] d);
        frd_w_v_i = 1; frd_addr_i = a; frd_data_i = d; cyc(); frd_w_v_i = 0;
    endtask

    typedef struct {
        logic cv; logic iv; logic [4:0] ia; logic [63:0] id; logic y;
        logic ev; logic [4:0] erd; logic [63:0] edata; logic [31:0] ecnt;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int retires;
        logic [63:0] r64;
        // addi x5 committed at row 0, its data arrives at row 3, retired at row 4
        tbl[0] = '{1, 0, 5'd0, 64'h0,    0, 0, 5'd0, 64'h0,    0};
        tbl[1] = '{0, 0, 5'd0, 64'h0,    0, 0, 5'd0, 64'h0,    0};
        tbl[2] = '{0, 0, 5'd0, 64'h0,    0, 0, 5'd0, 64'h0,    0};
        tbl[3] = '{0, 1, 5'd5, 64'h1234, 0, 0, 5'd0, 64'h0,    0};
        tbl[4] = '{0, 0, 5'd0, 64'h0,    1, 1, 5'd5, 64'h1234, 0};
        tbl[5] = '{0, 0, 5'd0, 64'h0,    0, 0, 5'd0, 64'h0,    1};

        en_i = 1; instr_cap_i = '0;
        do_reset();

        for (int k = 0; k < 6; k++) begin
            chk("tbl_v", 64'(retire_v_o), 64'(tbl[k].ev));
            if (tbl[k].ev) begin
                chk("tbl_rd", 64'(retire_rd_addr_o), 64'(tbl[k].erd));
                chk("tbl_data", retire_rd_data_o, tbl[k].edata);
            end
            chk("tbl_cnt", 64'(instr_cnt_o), 64'(tbl[k].ecnt));
            commit_v_i = tbl[k].cv; commit_pc_i = 39'h80; commit_instr_i = mk(5'd5);
            commit_ird_w_v_i = 1; ird_w_v_i = tbl[k].iv; ird_addr_i = tbl[k].ia;
            ird_data_i = tbl[k].id; retire_yumi_i = tbl[k].y;
            cyc();
        end
        clr();

        // two buffered x7 writes are consumed in order
        do_reset();
        iwb(5'd7, 64'hA); iwb(5'd7, 64'hB);
        do_commit(39'h100, mk(5'd7), 1, 0, 0, 64'h0);
        do_commit(39'h104, mk(5'd7), 1, 0, 0, 64'h0);
        chk("x7_first_v", 64'(retire_v_o), 64'd1);
        chk("x7_first", retire_rd_data_o, 64'hA);
        retire_yumi_i = 1; cyc();
        chk("x7_second", retire_rd_data_o, 64'hB);
        cyc(); retire_yumi_i = 0;
        chk("x7_cnt", 64'(instr_cnt_o), 64'd2);
        iwb(5'd9, 64'h1); iwb(5'd9, 64'h2);
        chk("int_ovf_before", 64'(overrun_o[1]), 64'd0);
        iwb(5'd9, 64'h3);
        chk("int_ovf", 64'(overrun_o[1]), 64'd1);

        // trap and x0 writer retire without waiting for data
        do_reset();
        do_commit(39'h200, mk(5'd5), 1, 0, 1, 64'h8);
        do_commit(39'h204, mk(5'd0), 1, 0, 0, 64'h0);
        chk("trap_v", 64'(retire_v_o), 64'd1);
        chk("trap_flag", 64'(retire_trap_o), 64'd1);
        chk("trap_cause", retire_cause_o, 64'h8);
        chk("trap_no_rd", 64'(retire_rd_w_v_o), 64'd0);
        retire_yumi_i = 1; cyc();
        chk("x0_v", 64'(retire_v_o), 64'd1);
        chk("x0_no_rd", 64'(retire_rd_w_v_o), 64'd0);
        cyc(); retire_yumi_i = 0;
        chk("trap_cnt", 64'(instr_cnt_o), 64'd1);

        // fill the commit FIFO, overflow once, then drain in order
        do_reset();
        for (int i = 0; i < CD; i++) do_commit(39'h1000 + 39'(4 * i), mk(5'd0), 0, 0, 0, 64'h0);
        chk("cfifo_ovf_before", 64'(overrun_o[0]), 64'd0);
        do_commit(39'hDEAD, mk(5'd0), 0, 0, 0, 64'h0);
        chk("cfifo_ovf", 64'(overrun_o[0]), 64'd1);
        retire_yumi_i = 1;
        for (int i = 0; i < CD; i++) begin
            chk("drain_pc", 64'(retire_pc_o), 64'h1000 + 64'(4 * i));
            cyc();
        end
        retire_yumi_i = 0;
        chk("drain_empty", 64'(retire_v_o), 64'd0);

        // instruction cap stops retirement at exactly three
        do_reset();
        instr_cap_i = 32'd3;
        for (int i = 0; i < 5; i++) do_commit(39'h2000 + 39'(4 * i), mk(5'd0), 0, 0, 0, 64'h0);
        retires = 0;
        for (int i = 0; i < 12; i++) begin
            retire_yumi_i = m_ev();
            if (retire_yumi_i) retires++;
            cyc();
        end
        retire_yumi_i = 0;
        chk("cap_retires", 64'(retires), 64'd3);
        chk("cap_flag", 64'(cap_reached_o), 64'd1);
        chk("cap_v", 64'(retire_v_o), 64'd0);
        instr_cap_i = '0;

        // stalled fp head trips the watchdog exactly after WD cycles
        do_reset();
        do_commit(39'h300, mk(5'd3), 0, 1, 0, 64'h0);
        for (int i = 0; i < WD - 1; i++) cyc();
        chk("wd_edge", 64'(watchdog_o), 64'd0);
        cyc();
        chk("wd_set", 64'(watchdog_o), 64'd1);
        reset_i = 1; cyc(); reset_i = 0;
        chk("rst_wd", 64'(watchdog_o), 64'd0);
        chk("rst_v", 64'(retire_v_o), 64'd0);
        chk("rst_cnt", 64'(instr_cnt_o), 64'd0);
        fwb(5'd3, 64'h55);
        chk("rst_fifo_empty", 64'(retire_v_o), 64'd0);

        // random traffic against the model, with a reset in the middle
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            reset_i          = (i == 1000);
            en_i             = ($urandom % 16) != 0;
            commit_v_i       = ($urandom % 3) == 0;
            r64              = {$urandom, $urandom};
            commit_pc_i      = r64[38:0];
            commit_instr_i   = $urandom;
            commit_instr_i[11:7] = 5'($urandom % 4);
            commit_ird_w_v_i = $urandom % 2;
            commit_frd_w_v_i = ($urandom % 4) == 0;
            commit_trap_i    = ($urandom % 10) == 0;
            commit_cause_i   = {$urandom, $urandom};
            commit_debug_i   = ($urandom % 12) == 0;
            ird_w_v_i        = ($urandom % 3) == 0;
            ird_addr_i       = 5'($urandom % 4);
            ird_data_i       = {$urandom, $urandom};
            frd_w_v_i        = ($urandom % 5) == 0;
            frd_addr_i       = 5'($urandom % 4);
            frd_data_i       = {$urandom, $urandom};
            retire_yumi_i    = m_ev() && (($urandom % 4) != 0);
            cyc();
        end
        clr(); reset_i = 0; en_i = 1;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
